// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues word-aligned fetches, pairs in-order responses
// with their issue addresses, and buffers {pc, instr} for the IF/ID register.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_id_write,
    output logic [63:0] if_id_d,
    output logic        if_id_valid
);
    // state | meaning
    // BOOT  | first cycle out of reset, no requests
    // RUN   | normal fetch, responses land in the buffer
    // DRAIN | stale responses from before a redirect are being discarded
    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_e;

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   aq_head_q, aq_head_d;
    logic [PW-1:0]   aq_tail_q, aq_tail_d;
    logic [31:0]     fifo_pc_q    [DEPTH];
    logic [31:0]     fifo_instr_q [DEPTH];
    logic [31:0]     aq_q         [DEPTH];

    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    logic [CW:0]     occ_sum;
    logic            unused_rpc_lsb;

    assign unused_rpc_lsb = ^redirect_pc[1:0];
    assign occ_sum        = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req_addr  = fetch_pc_q;
    assign if_id_valid    = (count_q != '0);
    assign if_id_d        = if_id_valid ? {fifo_pc_q[rd_ptr_q], fifo_instr_q[rd_ptr_q]} : 64'd0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        aq_head_d  = aq_head_q;
        aq_tail_d  = aq_tail_q;

        imem_req_valid = (state_q == RUN) && (occ_sum < (CW+1)'(DEPTH)) && !redirect_valid;
        req_fire       = imem_req_valid && imem_req_ready;
        // Responses with nothing outstanding cannot be ours (e.g. left over from before reset).
        rsp_fire       = imem_rsp_valid && (outst_q != '0);
        push           = rsp_fire && (drop_q == '0) && !redirect_valid;
        pop            = if_id_valid && if_id_write && !redirect_valid;

        outst_d = outst_q + CW'(req_fire) - CW'(rsp_fire);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            aq_tail_d  = aq_tail_q + PW'(1);
        end
        if (rsp_fire) begin
            aq_head_d = aq_head_q + PW'(1);
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            DRAIN:   state_d = (drop_d == '0) ? RUN : DRAIN;
            default: state_d = BOOT;
        endcase

        // Redirect overrides everything: every request still in flight becomes stale.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            drop_d     = outst_d;
            state_d    = (outst_d != '0) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            aq_head_q  <= '0;
            aq_tail_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            aq_head_q  <= aq_head_d;
            aq_tail_q  <= aq_tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            aq_q[aq_tail_q] <= fetch_pc_q;
        end
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= aq_q[aq_head_q];
            fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory model with programmable latency and an
// independent model of request gating, stale-response dropping and buffer contents.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_write;
    logic [63:0] if_id_d;
    logic        if_id_valid;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_write    (if_id_write),
        .if_id_d        (if_id_d),
        .if_id_valid    (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          stale;
        int          due;
    } mreq_t;

    mreq_t       pend[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    bit          boot;
    bit          after_rst;
    bit          started;
    int          cyc;
    int          seq;
    int          n_checks;
    int          n_fail;
    int          n_out;

    // stimulus knobs for the next cycle
    logic        s_rst, s_ready, s_rsp_en, s_redir, s_write;
    logic [31:0] s_rpc;
    int          lat;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int stale_cnt();
        int n = 0;
        foreach (pend[i]) if (pend[i].stale) n++;
        return n;
    endfunction

    task automatic tick();
        bit    rsp_now;
        bit    exp_valid;
        mreq_t h;
        rst            = s_rst;
        imem_req_ready = s_ready;
        redirect_valid = s_redir;
        redirect_pc    = s_rpc;
        if_id_write    = s_write;
        rsp_now        = 1'b0;
        if (!s_rst) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (pend.size() > 0 && pend[0].due <= cyc && s_rsp_en) begin
            rsp_now        = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_valid = !boot && (stale_cnt() == 0) && (exp_q.size() + pend.size() < DEPTH) && !s_redir;
        if (started && after_rst) begin
            check_val("rst_req_valid", 64'(imem_req_valid), 64'd0);
            check_val("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
            check_val("rst_if_id_valid", 64'(if_id_valid), 64'd0);
            check_val("rst_if_id_d", if_id_d, 64'd0);
        end else if (started && s_rst) begin
            check_val("req_valid", 64'(imem_req_valid), 64'(exp_valid));
            if (exp_valid) check_val("req_addr", 64'(imem_req_addr), 64'(exp_pc));
            check_val("if_id_valid", 64'(if_id_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) check_val("if_id_d", if_id_d, exp_q[0]);
        end
        if (!s_rst) begin
            pend.delete();
            exp_q.delete();
            exp_pc = RESET_PC;
            boot   = 1'b1;
        end else begin
            if (rsp_now) h = pend.pop_front();
            if (s_redir) begin
                exp_q.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
                exp_pc = {s_rpc[31:2], 2'b00};
            end else begin
                if (s_write && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
                if (rsp_now && !h.stale) exp_q.push_back({h.addr, h.data});
                if (exp_valid && s_ready) begin
                    pend.push_back('{addr: exp_pc, data: {16'(seq), exp_pc[15:0]}, stale: 1'b0, due: cyc + lat});
                    seq++;
                    exp_pc = exp_pc + 32'd4;
                end
            end
            boot = 1'b0;
        end
        after_rst = !s_rst;
        started   = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        s_redir = 1'b1;
        s_rpc   = pc;
        tick();
        s_redir = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_out = 0; cyc = 0; seq = 1;
        boot = 1'b1; after_rst = 1'b0; started = 1'b0; exp_pc = RESET_PC;
        s_rst = 1'b0; s_ready = 1'b1; s_rsp_en = 1'b1; s_redir = 1'b0; s_write = 1'b1;
        s_rpc = '0; lat = 1;

        // reset, then streaming with latency 1
        run(3);
        s_rst = 1'b1;
        run(12);

        // IF/ID stall fills the buffer, then resume
        s_write = 1'b0;
        run(5);
        s_write = 1'b1;
        run(8);

        // redirect with requests in flight
        lat = 3;
        run(2);
        redirect_to(32'h0000_0100);
        run(12);

        // unaligned redirect target and address wrap
        lat = 1;
        redirect_to(32'h0000_0203);
        run(6);
        redirect_to(32'hFFFF_FFFC);
        run(6);

        // redirect, second redirect while draining, reset mid-drain
        lat = 3;
        run(3);
        redirect_to(32'h0000_0300);
        redirect_to(32'h0000_0040);
        s_rst = 1'b0;
        run(2);
        s_rst = 1'b1;
        run(12);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            s_ready  = ($urandom_range(0, 3) != 0);
            s_rsp_en = ($urandom_range(0, 3) != 0);
            s_write  = ($urandom_range(0, 2) != 0);
            lat      = $urandom_range(1, 3);
            s_rst    = ($urandom_range(0, 149) != 0) || after_rst;
            if (s_rst && !after_rst && $urandom_range(0, 19) == 0) begin
                redirect_to(($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom);
            end else begin
                tick();
            end
        end
        s_rst = 1'b1; s_ready = 1'b1; s_rsp_en = 1'b1; s_write = 1'b1;
        run(10);

        check_val("progress", 64'(n_out > 40), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the fetch buffer entry count (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_addr  output  32  fetch byte address, word aligned.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction return, in request order, latency >= 1 cycle.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump taken; restart fetch.
REQ-011 SHALL have port redirect_pc  input  32  restart address.
REQ-012 SHALL have port if_id_write  input  1  IF/ID register enable; 1 = head entry consumed.
REQ-013 SHALL have port if_id_d  output  64  {pc[31:0], instr[31:0]} of buffer head, IF/ID register data input.
REQ-014 SHALL have port if_id_valid  output  1  buffer non-empty.

Function
REQ-015 SHALL hold fetch_pc, outstanding count (0..DEPTH), drop count, DEPTH-entry FIFO of {pc, instr}, and FSM {BOOT, RUN, DRAIN}.
REQ-016 SHALL keep a DEPTH-entry in-order queue of issued addresses; each response pairs with the oldest queued address.
REQ-017 SHALL enter BOOT out of reset, go to RUN the next cycle, and keep imem_req_valid=0 during BOOT.
REQ-018 SHALL drive imem_req_valid=1 in RUN only when occupancy + outstanding < DEPTH and redirect_valid=0; imem_req_addr = fetch_pc.
REQ-019 SHALL, on handshake (imem_req_valid & imem_req_ready), increment outstanding and advance fetch_pc by 4, wrapping modulo 2^32.
REQ-020 SHALL keep imem_req_valid and imem_req_addr stable while imem_req_ready=0, except when a redirect occurs.
REQ-021 SHALL, on imem_rsp_valid with drop count 0, decrement outstanding and write {paired pc, imem_rsp_data} to the FIFO tail, visible on if_id_d the next cycle (fetch-to-output latency: response cycle + 1).
REQ-022 SHALL pop the head when if_id_valid & if_id_write; push and pop in the same cycle leave occupancy unchanged.
REQ-023 SHALL hold if_id_d stable while if_id_write=0 (stall); if_id_d is don't-care when if_id_valid=0.
REQ-024 SHALL, on redirect_valid, in the same edge: set fetch_pc = {redirect_pc[31:2], 2'b00}, empty the FIFO, set drop count = outstanding after this cycle's response, issue no request that cycle.
REQ-025 SHALL go to DRAIN after a redirect if drop count > 0, otherwise stay in or go to RUN.
REQ-026 SHALL, in DRAIN, discard each response (decrement outstanding and drop count, no FIFO write), suppress requests, and return to RUN when drop count reaches 0.
REQ-027 SHALL treat a redirect during DRAIN as REQ-024; only fetch_pc changes and all outstanding responses stay stale.
REQ-028 SHALL give redirect priority over pop, push and issue in the same cycle; a pop in the redirect cycle has no effect beyond the flush.
REQ-029 SHALL never overflow the FIFO (guaranteed by REQ-018) or underflow it (pop gated by if_id_valid).

Reset
REQ-030 SHALL, at a rising edge with rst=0, set state=BOOT, fetch_pc=RESET_PC, outstanding=0, drop=0, FIFO empty, address queue empty.
REQ-031 SHALL drive imem_req_valid=0, if_id_valid=0, imem_req_addr=RESET_PC, if_id_d=0 while rst=0 and the cycle after release.
REQ-032 SHALL ignore imem_rsp_valid and redirect_valid while rst=0; reset mid-operation discards all outstanding responses without tracking them.

Verification
REQ-033 SHALL cover: reset release with ready=1, rsp latency 1, if_id_write=1 -> requests at 0x0, 0x4, 0x8; if_id_d = {0x0, instr0}, then {0x4, instr1}, one per cycle.
REQ-034 SHALL cover: if_id_write=0 for 5 cycles -> FIFO fills to 2, imem_req_valid drops to 0, if_id_d held at {0x0, instr0}; the order resumes unchanged on release.
REQ-035 SHALL cover: redirect_pc=0x100 with 2 outstanding -> DRAIN, both responses discarded, the next request is 0x100, and the first output is {0x100, instrX}.
REQ-036 SHALL cover: redirect_pc=0x203 -> imem_req_addr=0x200.
REQ-037 SHALL cover: fetch_pc=0xFFFF_FFFC -> the next request address is 0x0000_0000.
REQ-038 SHALL cover: redirect, a second redirect to 0x40 in DRAIN, and rst=0 asserted mid-DRAIN -> after reset, requests restart at RESET_PC and no stale instruction appears on if_id_d.
